ccd_frame_capture: RTL and testbench

Raw Bayer frame capture stage sitting directly upstream of the grey/edge image-processing stage. It samples the sensor's 12-bit pixel bus with frame-valid and line-valid strobes, gates whole frames under start/stop run control, and emits pixel data with a data-valid strobe and X/Y pixel counters. The counters' LSBs drive downstream Bayer phase decoding, so X/Y must be exact and frame-aligned.

---
 rtl/ccd_frame_capture_pkg.sv | 12 +
 rtl/ccd_frame_capture_if.sv | 17 +
 rtl/ccd_frame_capture_pixel_xy_counter.sv | 31 +++
 rtl/ccd_frame_capture.sv | 102 ++++++++++
 tb/tb_ccd_frame_capture.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ccd_frame_capture_pkg.sv
// ccd_frame_capture_pkg: shared widths, default frame geometry and capture state encoding
package ccd_frame_capture_pkg;
   localparam int PIX_W        = 12;
   localparam int CNT_W        = 11;
   localparam int H_ACTIVE_DEF = 1280;
   localparam int V_ACTIVE_DEF = 960;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   typedef logic [PIX_W-1:0] pix_t;
   typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/ccd_frame_capture_if.sv
// ccd_frame_capture_if: sensor bus, run control and captured pixel stream
interface ccd_frame_capture_if;
   import ccd_frame_capture_pkg::*;
   pix_t        raw;
   logic        fval;
   logic        lval;
   logic        start;
   logic        stop;
   pix_t        pix;
   logic        dval;
   cnt_t        x;
   cnt_t        y;
   logic [31:0] frame_cnt;
   logic        sync_err;
   modport master (output raw, fval, lval, start, stop, input pix, dval, x, y, frame_cnt, sync_err);
   modport slave  (input raw, fval, lval, start, stop, output pix, dval, x, y, frame_cnt, sync_err);
endinterface

// File: rtl/ccd_frame_capture_pixel_xy_counter.sv
// pixel_xy_counter: column/row position of the next emitted pixel, with line wrap, row saturation and end-of-line resync
module pixel_xy_counter
   import ccd_frame_capture_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   input  logic eol,
   output cnt_t x,
   output cnt_t y
);
   localparam cnt_t X_LAST = cnt_t'(H_ACTIVE - 1);
   localparam cnt_t Y_LAST = cnt_t'(V_ACTIVE - 1);
   // a line ends either at the last column or when the sensor drops line-valid early
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (inc) begin
         x <= (eol || x == X_LAST) ? '0 : x + 1'b1;
         y <= (eol || x == X_LAST) ? ((y == Y_LAST) ? y : y + 1'b1) : y;
      end
   end
endmodule

// File: rtl/ccd_frame_capture.sv
// ccd_frame_capture: gates whole Bayer frames under start/stop control and tags pixels with X/Y;
// define CAPTURE_SYNC_ERR_EN to build the sticky line-length error flag
module ccd_frame_capture
   import ccd_frame_capture_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF
) (
   input logic              clk,
   input logic              rst_n,
   ccd_frame_capture_if.slave bus
);
   logic [1:0] state, state_nx;
   pix_t       m_data, d2;
   logic       m_fval, m_lval, fval_q, lval2, stop_pending;
   logic       rise, fall, enter, inc, eol;
   cnt_t       cx, cy;
   // input stage plus one alignment stage so the pixel lines up with the state it is judged against;
   // frame-valid history resets high so a frame already running at reset release never looks like a new one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_data <= '0;
         m_fval <= 1'b1;
         m_lval <= 1'b0;
         fval_q <= 1'b1;
         d2     <= '0;
         lval2  <= 1'b0;
      end else begin
         m_data <= bus.raw;
         m_fval <= bus.fval;
         m_lval <= bus.lval;
         fval_q <= m_fval;
         d2     <= m_data;
         lval2  <= m_lval;
      end
   end
   // edge detection and next state; stop beats start and beats a frame start while armed
   always_comb begin
      rise     = m_fval & ~fval_q;
      fall     = ~m_fval & fval_q;
      state_nx = (state == ST_IDLE)   ? ((bus.start && !bus.stop) ? ST_ARMED : ST_IDLE) :
                 (state == ST_ARMED)  ? (bus.stop ? ST_IDLE : (rise ? ST_ACTIVE : ST_ARMED)) :
                 (state == ST_ACTIVE) ? (!fall ? ST_ACTIVE : ((stop_pending || bus.stop) ? ST_IDLE : ST_ARMED)) :
                 ST_IDLE;
      enter    = (state == ST_ARMED) && (state_nx == ST_ACTIVE);
      inc      = (state == ST_ACTIVE) && lval2;
      eol      = lval2 && !m_lval;
   end
   // run control: a stop during a frame is remembered and honoured at frame end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         stop_pending  <= 1'b0;
         bus.frame_cnt <= '0;
      end else begin
         state         <= state_nx;
         stop_pending  <= (state == ST_ACTIVE) && !fall && (stop_pending || bus.stop);
         bus.frame_cnt <= bus.frame_cnt + {31'd0, enter};
      end
   end
   pixel_xy_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_xy (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (enter),
      .inc  (inc),
      .eol  (eol),
      .x    (cx),
      .y    (cy)
   );
   // output register; coordinates hold between pixels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.dval <= 1'b0;
         bus.pix  <= '0;
         bus.x    <= '0;
         bus.y    <= '0;
      end else begin
         bus.dval <= inc;
         if (inc) begin
            bus.pix <= d2;
            bus.x   <= cx;
            bus.y   <= cy;
         end
      end
   end
`ifdef CAPTURE_SYNC_ERR_EN
   logic armed_start, err;
   // a line is bad when its end and the last column disagree; cleared only by a start-initiated capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_start <= 1'b0;
         err         <= 1'b0;
      end else begin
         armed_start <= (state == ST_IDLE && state_nx == ST_ARMED) ? 1'b1 : (enter ? 1'b0 : armed_start);
         err         <= (enter && armed_start) ? 1'b0 : (err | (inc && (eol != (cx == cnt_t'(H_ACTIVE - 1)))));
      end
   end
   assign bus.sync_err = err;
`else
   assign bus.sync_err = 1'b0;
`endif
endmodule

// File: tb/tb_ccd_frame_capture.sv
// tb_ccd_frame_capture: directed frames against a pixel scoreboard (geometry scaled to 32 columns)
module tb_ccd_frame_capture;
   localparam int H = 32;
   localparam int V = 960;
`ifdef CAPTURE_SYNC_ERR_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif
   typedef struct {
      logic [11:0] d;
      logic [10:0] x;
      logic [10:0] y;
      int          c;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ccd_frame_capture_if bus ();
   ccd_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   exp_t q[$];
   int   errs = 0;
   int   checks = 0;
   int   cyc = 0;
   int   npix = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      exp_t e;
      @(negedge clk);
      cyc++;
      if (bus.dval === 1'b1) begin
         npix++;
         chk("dval_expected", {31'd0, bus.dval}, {31'd0, q.size() != 0});
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("pix", {20'd0, bus.pix}, {20'd0, e.d});
            chk("x", {21'd0, bus.x}, {21'd0, e.x});
            chk("y", {21'd0, bus.y}, {21'd0, e.y});
            chk("latency", cyc, e.c);
         end
      end
   endtask

   task automatic drv(input logic fv, input logic lv, input logic cap, input int l, input int p,
                      input logic st, input logic sp);
      logic [11:0] d;
      int          yy;
      tick();
      d = 12'($urandom);
      bus.raw = d;
      bus.fval = fv;
      bus.lval = lv;
      bus.start = st;
      bus.stop = sp;
      yy = (l < V) ? l : V - 1;
      if (cap && lv) q.push_back('{d, 11'(p), 11'(yy), cyc + 3});
   endtask

   task automatic frame(input int lines, input int len, input logic cap, input int sl, input int slen, input int stl);
      repeat (3) drv(0, 0, 0, 0, 0, 0, 0);
      repeat (2) drv(1, 0, 0, 0, 0, 0, 0);
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ((l == sl) ? slen : len); p++) drv(1, 1, cap, l, p, 0, (l == stl) && (p == 0));
         repeat (3) drv(1, 0, 0, 0, 0, 0, 0);
      end
      repeat (3) drv(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic check_end(input string tag, input int exp_pix, input int fc, input int lx, input int ly);
      chk({tag, "_count"}, npix, exp_pix);
      chk({tag, "_drained"}, q.size(), 0);
      chk({tag, "_frame_cnt"}, bus.frame_cnt, fc);
      chk({tag, "_last_x"}, {21'd0, bus.x}, lx);
      chk({tag, "_last_y"}, {21'd0, bus.y}, ly);
   endtask

   initial begin
      bus.raw = '0;
      bus.fval = 1'b0;
      bus.lval = 1'b0;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      repeat (3) tick();
      chk("rst_pix", {20'd0, bus.pix}, 0);
      chk("rst_dval", {31'd0, bus.dval}, 0);
      chk("rst_x", {21'd0, bus.x}, 0);
      chk("rst_y", {21'd0, bus.y}, 0);
      chk("rst_frame_cnt", bus.frame_cnt, 0);
      chk("rst_sync_err", {31'd0, bus.sync_err}, 0);
      rst_n = 1'b1;
      repeat (3) drv(0, 0, 0, 0, 0, 0, 0);

      // arm in the middle of a running frame: that frame is skipped, the next is captured
      npix = 0;
      repeat (2) drv(1, 0, 0, 0, 0, 0, 0);
      for (int l = 0; l < 4; l++) begin
         for (int p = 0; p < H; p++) drv(1, 1, 0, l, p, (l == 0) && (p == 5), 0);
         repeat (3) drv(1, 0, 0, 0, 0, 0, 0);
      end
      chk("midarm_skipped", npix, 0);
      frame(4, H, 1, -1, 0, -1);
      check_end("frame1", 4 * H, 1, H - 1, 3);

      // stop during line 2: frame completes, following frame ignored
      npix = 0;
      frame(4, H, 1, -1, 0, 2);
      frame(4, H, 0, -1, 0, -1);
      check_end("stop", 4 * H, 2, H - 1, 3);

      // re-arm, then a short line 1
      drv(0, 0, 0, 0, 0, 1, 0);
      npix = 0;
      frame(4, H, 1, 1, 10, -1);
      check_end("short", 3 * H + 10, 3, H - 1, 3);
      chk("short_sync_err", {31'd0, bus.sync_err}, {31'd0, EXP_ERR});

      // 1000 lines: row saturates at V-1
      npix = 0;
      frame(1000, H, 1, -1, 0, -1);
      check_end("tall", 1000 * H, 4, H - 1, V - 1);

      // reset in the middle of a captured line
      repeat (2) drv(0, 0, 0, 0, 0, 0, 0);
      repeat (2) drv(1, 0, 0, 0, 0, 0, 0);
      for (int p = 0; p < 8; p++) drv(1, 1, 1, 0, p, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_pix", {20'd0, bus.pix}, 0);
      chk("midrst_dval", {31'd0, bus.dval}, 0);
      chk("midrst_x", {21'd0, bus.x}, 0);
      chk("midrst_y", {21'd0, bus.y}, 0);
      chk("midrst_frame_cnt", bus.frame_cnt, 0);
      q.delete();
      npix = 0;
      for (int p = 8; p < 12; p++) drv(1, 1, 0, 0, p, 0, 0);
      rst_n = 1'b1;
      for (int p = 12; p < H; p++) drv(1, 1, 0, 0, p, p == 14, 0);
      for (int l = 1; l < 3; l++) begin
         repeat (3) drv(1, 0, 0, 0, 0, 0, 0);
         for (int p = 0; p < H; p++) drv(1, 1, 0, l, p, 0, 0);
      end
      repeat (3) drv(1, 0, 0, 0, 0, 0, 0);
      chk("rearm_skipped", npix, 0);
      frame(2, H, 1, -1, 0, -1);
      check_end("rearm", 2 * H, 1, H - 1, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
